// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: FUNCT codes, HI/LO width, the
// multiply/divide unit state encoding and a small two's-complement helper.
package mips_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MULT = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state;

  // Two's-complement negation; wraps for the most negative value.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Unsigned magnitude of a signed word; 0x80000000 maps to 2^31.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

endpackage

// File: rtl/mult_div_unit_div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Trial subtraction; a clear borrow bit means the divisor fits.
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
    q_bit     = ~diff_s[WIDTH+1];
    if (q_bit) begin
      rem_out = diff_s[WIDTH:0];
    end else begin
      rem_out = shifted_s;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit
// owning the HI/LO pair. All outputs come straight from registers.
module mult_div_unit #(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  import mips_pkg::*;

  mdu_state         state_r, state_nx_s;
  logic [4:0]       cnt_r;
  logic [WIDTH:0]   a_r;        // Booth A (sign-extended) or partial remainder
  logic [WIDTH-1:0] q_r;        // Booth Q or dividend/quotient shift register
  logic             qm1_r;      // Booth q-1
  logic [WIDTH:0]   m_r;        // sign-extended multiplicand or divisor magnitude
  logic             sign_a_r;   // remainder sign follows the dividend
  logic             sign_q_r;   // quotient negative when operand signs differ
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             busy_r, done_r, div_zero_r;

  logic [WIDTH:0]   booth_add_s;
  logic [WIDTH:0]   booth_a_nx_s;
  logic [WIDTH-1:0] booth_q_nx_s;
  logic [WIDTH:0]   step_rem_s;
  logic             step_qbit_s;
  logic [WIDTH-1:0] quo_mag_s;
  logic             last_iter_s;

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (a_r[WIDTH-1:0]),
    .dividend_bit (q_r[WIDTH-1]),
    .divisor      (m_r[WIDTH-1:0]),
    .rem_out      (step_rem_s),
    .q_bit        (step_qbit_s)
  );

  // Booth add/subtract followed by arithmetic right shift of {A, Q, q-1}.
  always_comb begin
    case ({q_r[0], qm1_r})
      2'b01:   booth_add_s = a_r + m_r;
      2'b10:   booth_add_s = a_r - m_r;
      default: booth_add_s = a_r;
    endcase
    booth_a_nx_s = {booth_add_s[WIDTH], booth_add_s[WIDTH:1]};
    booth_q_nx_s = {booth_add_s[0], q_r[WIDTH-1:1]};
    quo_mag_s    = {q_r[WIDTH-2:0], step_qbit_s};
    last_iter_s  = (cnt_r == 5'd31);
  end

  // Next-state logic; multiply wins over a simultaneous divide request.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      MDU_IDLE: begin
        if (mult_start) begin
          state_nx_s = MDU_MULT;
        end else if (div_start) begin
          if (op_b == {WIDTH{1'b0}}) begin
            state_nx_s = MDU_DONE;
          end else begin
            state_nx_s = MDU_DIV;
          end
        end else begin
          state_nx_s = MDU_IDLE;
        end
      end
      MDU_MULT, MDU_DIV: begin
        if (last_iter_s) begin
          state_nx_s = MDU_DONE;
        end else begin
          state_nx_s = state_r;
        end
      end
      MDU_DONE: state_nx_s = MDU_IDLE;
      default:  state_nx_s = MDU_IDLE;
    endcase
  end

  // State, datapath and registered outputs; HI/LO only move entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= MDU_IDLE;
      cnt_r      <= 5'd0;
      a_r        <= {(WIDTH+1){1'b0}};
      q_r        <= {WIDTH{1'b0}};
      qm1_r      <= 1'b0;
      m_r        <= {(WIDTH+1){1'b0}};
      sign_a_r   <= 1'b0;
      sign_q_r   <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == MDU_MULT) || (state_nx_s == MDU_DIV);
      done_r  <= (state_nx_s == MDU_DONE);
      case (state_r)
        MDU_IDLE: begin
          cnt_r <= 5'd0;
          if (state_nx_s == MDU_MULT) begin
            a_r        <= {(WIDTH+1){1'b0}};
            q_r        <= op_b;
            qm1_r      <= 1'b0;
            m_r        <= {op_a[WIDTH-1], op_a};
            div_zero_r <= 1'b0;
          end else if (state_nx_s == MDU_DIV) begin
            a_r        <= {(WIDTH+1){1'b0}};
            q_r        <= magnitude(op_a);
            m_r        <= {1'b0, magnitude(op_b)};
            sign_a_r   <= op_a[WIDTH-1];
            sign_q_r   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            div_zero_r <= 1'b0;
          end else if (state_nx_s == MDU_DONE) begin
            div_zero_r <= 1'b1;
          end
        end
        MDU_MULT: begin
          a_r   <= booth_a_nx_s;
          q_r   <= booth_q_nx_s;
          qm1_r <= q_r[0];
          cnt_r <= cnt_r + 5'd1;
          if (last_iter_s) begin
            hi_r <= booth_a_nx_s[WIDTH-1:0];
            lo_r <= booth_q_nx_s;
          end
        end
        MDU_DIV: begin
          a_r   <= step_rem_s;
          q_r   <= quo_mag_s;
          cnt_r <= cnt_r + 5'd1;
          if (last_iter_s) begin
            lo_r <= sign_q_r ? negate(quo_mag_s) : quo_mag_s;
            hi_r <= sign_a_r ? negate(step_rem_s[WIDTH-1:0]) : step_rem_s[WIDTH-1:0];
          end
        end
        MDU_DONE: cnt_r <= 5'd0;
        default:  cnt_r <= 5'd0;
      endcase
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed expected values.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int n_cmp = 0;
  int n_fail = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Issues one request and waits (bounded) for done. cyc counts the cycle
  // after the accepting edge as 1, so the done cycle of a full op is 33.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, output int cyc,
                        output logic busy_all, output logic busy_at_done,
                        output logic busy_any);
    while (done === 1'b1) begin @(posedge clk); #1; end
    @(negedge clk);
    mult_start = m; div_start = d; op_a = a; op_b = b;
    @(posedge clk); #1;
    mult_start = 1'b0; div_start = 1'b0;
    cyc = 1; busy_all = 1'b1; busy_any = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_all = 1'b0;
      if (busy === 1'b1) busy_any = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    busy_at_done = busy;
    if (busy === 1'b1) busy_any = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
    n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int cyc; logic ba, bd, by;
    run_op(1'b1, 1'b0, 32'h7, 32'hFFFFFFFD, cyc, ba, bd, by);
    n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
    n_cmp++; if (ba !== 1'b1) begin n_fail++; $display("FAIL mult_busy_during: got %b expected 1", ba); end
    n_cmp++; if (bd !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done: got %b expected 0", bd); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_7x-3_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
    n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_7x-3_lo: got %h expected %h", lo, 32'hFFFFFFEB); end
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, cyc, ba, bd, by);
    n_cmp++; if (hi !== 32'h40000000) begin n_fail++; $display("FAIL mult_min_hi: got %h expected %h", hi, 32'h40000000); end
    n_cmp++; if (lo !== 32'h00000000) begin n_fail++; $display("FAIL mult_min_lo: got %h expected %h", lo, 32'h0); end
  endtask

  task automatic test_div();
    int cyc; logic ba, bd, by;
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'h2, cyc, ba, bd, by);   // -7 / 2
    n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", cyc); end
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_-7/2_lo: got %h expected %h", lo, 32'hFFFFFFFD); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_-7/2_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
    n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL div_-7/2_dz: got %b expected 0", div_zero); end
    run_op(1'b0, 1'b1, 32'h7, 32'hFFFFFFFE, cyc, ba, bd, by);   // 7 / -2
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_7/-2_lo: got %h expected %h", lo, 32'hFFFFFFFD); end
    n_cmp++; if (hi !== 32'h00000001) begin n_fail++; $display("FAIL div_7/-2_hi: got %h expected %h", hi, 32'h1); end
    run_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, cyc, ba, bd, by); // -100 / -7
    n_cmp++; if (lo !== 32'h0000000E) begin n_fail++; $display("FAIL div_-100/-7_lo: got %h expected %h", lo, 32'hE); end
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL div_-100/-7_hi: got %h expected %h", hi, 32'hFFFFFFFE); end
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, cyc, ba, bd, by);
    n_cmp++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected %h", lo, 32'h80000000); end
    n_cmp++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected %h", hi, 32'h0); end
  endtask

  // Runs right after the overflow divide, so HI/LO hold 0 / 0x80000000.
  task automatic test_div_zero();
    int cyc; logic ba, bd, by;
    run_op(1'b0, 1'b1, 32'h5, 32'h0, cyc, ba, bd, by);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", cyc); end
    n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
    n_cmp++; if (by !== 1'b0) begin n_fail++; $display("FAIL dz_busy_seen: got %b expected 0", by); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL dz_hi_kept: got %h expected %h", hi, 32'h0); end
    n_cmp++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL dz_lo_kept: got %h expected %h", lo, 32'h80000000); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL dz_done_pulse: got %b expected 0", done); end
    n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag_held: got %b expected 1", div_zero); end
  endtask

  task automatic test_both_starts();
    int cyc; logic ba;
    while (done === 1'b1) begin @(posedge clk); #1; end
    @(negedge clk);
    mult_start = 1'b1; div_start = 1'b1; op_a = 32'd6; op_b = 32'd3;
    @(posedge clk); #1;
    mult_start = 1'b0; div_start = 1'b0;
    n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL both_dz_cleared: got %b expected 0", div_zero); end
    cyc = 1; ba = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) ba = 1'b0;
      div_start = (cyc == 5);
      op_b = (cyc == 5) ? 32'd0 : 32'd3;
      @(posedge clk); #1;
      cyc++;
    end
    div_start = 1'b0;
    n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL both_latency: got %0d expected 33", cyc); end
    n_cmp++; if (ba !== 1'b1) begin n_fail++; $display("FAIL both_busy_during: got %b expected 1", ba); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_busy_at_done: got %b expected 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL both_hi: got %h expected %h", hi, 32'd0); end
    n_cmp++; if (lo !== 32'd18) begin n_fail++; $display("FAIL both_lo: got %h expected %h", lo, 32'd18); end
    n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL both_dz: got %b expected 0", div_zero); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL both_back_idle: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_reset_mid_div();
    int cyc; logic ba, bd, by;
    @(negedge clk);
    div_start = 1'b1; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h/%h expected 0/0", hi, lo); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got busy=%b done=%b dz=%b expected 0 0 0", busy, done, div_zero);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard: got busy=%b done=%b expected 0 0", busy, done); end
    run_op(1'b1, 1'b0, 32'd2, 32'd3, cyc, ba, bd, by);
    n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL rst_then_mult_latency: got %0d expected 33", cyc); end
    n_cmp++; if (lo !== 32'd6 || hi !== 32'd0) begin n_fail++; $display("FAIL rst_then_mult: got %h/%h expected 0/6", hi, lo); end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_both_starts();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
